// File: rtl/uart_pkg.sv
// Shared definitions for the UART command controller: FSM encoding,
// default packet header, baud-register address and the checksum helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_DEF = 8'h55;
    localparam logic [7:0] BAUD_ADDR  = 8'h00;

    // 8-bit packet checksum: ADDR + DATA, carry discarded
    function automatic logic [7:0] csum8(input logic [7:0] addr, input logic [7:0] data);
        return addr + data;
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter. Counts while enabled, restarts on clear,
// and flags expiry combinationally in the cycle the count sits at the
// terminal value (suppressed when clear arrives in that same cycle).
module uart_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    // Expiry: terminal count reached with no byte arriving this cycle
    always_comb begin
        expire = enable && !clear && (cnt == TERM);
    end

    // Counter: held at zero while idle or cleared, wraps after expiry
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// UART command controller: parses HEADER/ADDR/DATA/CSUM packets from the
// receiver byte stream, issues register writes on good packets, updates
// the baud selection on writes to BAUD_ADDR and reports checksum and
// inter-byte timeout errors.
module uart_rx_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter logic [7:0]  HEADER      = HEADER_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Rx_Done,
    input  logic [7:0]  Data_Byte,
    output logic [2:0]  Baud_Set,
    output logic        Wr_En,
    output logic [7:0]  Wr_Addr,
    output logic [7:0]  Wr_Data,
    output logic        Err_Csum,
    output logic        Err_Timeout,
    output logic [15:0] Pkt_Cnt,
    output logic        Busy
);

    state_t state;
    logic   tmo_expire;

    // Busy reflects any in-progress packet
    always_comb begin
        Busy = (state != IDLE);
    end

    // Every received byte restarts the timeout; the counter only runs mid-packet
    uart_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .clear  (Rx_Done),
        .enable (Busy),
        .expire (tmo_expire)
    );

    // Packet FSM with registered write/error strobes; a received byte takes
    // precedence over a timeout expiring in the same cycle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            Baud_Set    <= 3'd0;
            Wr_En       <= 1'b0;
            Wr_Addr     <= '0;
            Wr_Data     <= '0;
            Err_Csum    <= 1'b0;
            Err_Timeout <= 1'b0;
            Pkt_Cnt     <= '0;
        end else begin
            Wr_En       <= 1'b0;
            Err_Csum    <= 1'b0;
            Err_Timeout <= 1'b0;
            if (Rx_Done) begin
                case (state)
                    IDLE: begin
                        if (Data_Byte == HEADER) begin
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        Wr_Addr <= Data_Byte;
                        state   <= DATA;
                    end
                    DATA: begin
                        Wr_Data <= Data_Byte;
                        state   <= CSUM;
                    end
                    CSUM: begin
                        state <= IDLE;
                        if (Data_Byte == csum8(Wr_Addr, Wr_Data)) begin
                            Wr_En   <= 1'b1;
                            Pkt_Cnt <= Pkt_Cnt + 16'd1;
                            if (Wr_Addr == BAUD_ADDR) begin
                                Baud_Set <= Wr_Data[2:0];
                            end
                        end else begin
                            Err_Csum <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (tmo_expire) begin
                state       <= IDLE;
                Err_Timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge following the rising edge that consumed the byte.
module tb_uart_rx_cmd_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        Rx_Done;
    logic [7:0]  Data_Byte;
    logic [2:0]  Baud_Set;
    logic        Wr_En;
    logic [7:0]  Wr_Addr;
    logic [7:0]  Wr_Data;
    logic        Err_Csum;
    logic        Err_Timeout;
    logic [15:0] Pkt_Cnt;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    uart_rx_cmd_ctrl #(
        .TIMEOUT_CYC (100),
        .HEADER      (8'h55)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Rx_Done     (Rx_Done),
        .Data_Byte   (Data_Byte),
        .Baud_Set    (Baud_Set),
        .Wr_En       (Wr_En),
        .Wr_Addr     (Wr_Addr),
        .Wr_Data     (Wr_Data),
        .Err_Csum    (Err_Csum),
        .Err_Timeout (Err_Timeout),
        .Pkt_Cnt     (Pkt_Cnt),
        .Busy        (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    // One Rx_Done strobe; returns on the falling edge after it is consumed
    task automatic send_byte(input logic [7:0] b);
        Rx_Done   = 1'b1;
        Data_Byte = b;
        @(negedge Clk);
        Rx_Done   = 1'b0;
        Data_Byte = 8'h00;
    endtask

    task automatic good_packet(input string tag, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] c;
        c = a + d;
        send_byte(8'h55);
        send_byte(a);
        send_byte(d);
        send_byte(c);
        exp_cnt = exp_cnt + 16'd1;
        check({tag, "_wr_en"},   32'(Wr_En),   32'd1);
        check({tag, "_wr_addr"}, 32'(Wr_Addr), 32'(a));
        check({tag, "_wr_data"}, 32'(Wr_Data), 32'(d));
        check({tag, "_pkt_cnt"}, 32'(Pkt_Cnt), 32'(exp_cnt));
        check({tag, "_no_err"},  32'({Err_Csum, Err_Timeout}), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     32'(Busy),        32'd0);
        check({tag, "_baud"},     32'(Baud_Set),    32'd0);
        check({tag, "_wr_en"},    32'(Wr_En),       32'd0);
        check({tag, "_wr_addr"},  32'(Wr_Addr),     32'd0);
        check({tag, "_wr_data"},  32'(Wr_Data),     32'd0);
        check({tag, "_err_csum"}, 32'(Err_Csum),    32'd0);
        check({tag, "_err_tmo"},  32'(Err_Timeout), 32'd0);
        check({tag, "_pkt_cnt"},  32'(Pkt_Cnt),     32'd0);
    endtask

    initial begin
        Rst_n     = 1'b0;
        Rx_Done   = 1'b0;
        Data_Byte = 8'h00;
        idle_cycles(3);
        check_reset_values("por");
        Rst_n = 1'b1;
        idle_cycles(2);

        // Basic good packet and one-cycle write strobe
        good_packet("pkt1", 8'h10, 8'hA5);
        @(negedge Clk);
        check("pkt1_wr_en_drop", 32'(Wr_En), 32'd0);
        check("pkt1_busy_after", 32'(Busy), 32'd0);

        // Baud register writes, back-to-back packets with no gap
        check("baud_before", 32'(Baud_Set), 32'd0);
        good_packet("baud3", 8'h00, 8'h03);
        check("baud3_val", 32'(Baud_Set), 32'd3);
        good_packet("baud4", 8'h00, 8'hFC);
        check("baud4_val", 32'(Baud_Set), 32'd4);

        // Checksum mismatch
        send_byte(8'h55);
        send_byte(8'h10);
        check("csum_busy_mid", 32'(Busy), 32'd1);
        send_byte(8'hA5);
        send_byte(8'h00);
        check("csum_err",     32'(Err_Csum), 32'd1);
        check("csum_no_wr",   32'(Wr_En),    32'd0);
        check("csum_pkt_cnt", 32'(Pkt_Cnt),  32'(exp_cnt));
        check("csum_busy",    32'(Busy),     32'd0);
        @(negedge Clk);
        check("csum_err_drop", 32'(Err_Csum), 32'd0);

        // HEADER value inside the payload is data, not a restart
        good_packet("hdr_payload", 8'h55, 8'h55);

        // Inter-byte timeout: pulse exactly 100 cycles after the last byte
        send_byte(8'h55);
        send_byte(8'h10);
        idle_cycles(99);
        check("tmo_not_yet",  32'(Err_Timeout), 32'd0);
        check("tmo_busy_pre", 32'(Busy),        32'd1);
        @(negedge Clk);
        check("tmo_pulse",    32'(Err_Timeout), 32'd1);
        check("tmo_idle",     32'(Busy),        32'd0);
        @(negedge Clk);
        check("tmo_drop",     32'(Err_Timeout), 32'd0);
        good_packet("after_tmo", 8'h22, 8'h33);

        // Byte arriving in the expiry cycle wins over the timeout
        send_byte(8'h55);
        send_byte(8'h10);
        idle_cycles(99);
        send_byte(8'hA5);
        check("coinc_no_tmo", 32'(Err_Timeout), 32'd0);
        check("coinc_busy",   32'(Busy),        32'd1);
        send_byte(8'hB5);
        exp_cnt = exp_cnt + 16'd1;
        check("coinc_wr_en",   32'(Wr_En),   32'd1);
        check("coinc_wr_addr", 32'(Wr_Addr), 32'h10);
        check("coinc_wr_data", 32'(Wr_Data), 32'hA5);
        check("coinc_pkt_cnt", 32'(Pkt_Cnt), 32'(exp_cnt));

        // Non-header bytes in IDLE are ignored silently
        send_byte(8'h00);
        send_byte(8'hAA);
        check("lead_busy", 32'(Busy), 32'd0);
        check("lead_err",  32'({Err_Csum, Err_Timeout}), 32'd0);
        good_packet("after_lead", 8'h01, 8'hFF);

        // Reset in the middle of a packet
        send_byte(8'h55);
        send_byte(8'h10);
        Rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        idle_cycles(2);
        check("midrst_no_err", 32'({Err_Csum, Err_Timeout}), 32'd0);
        Rst_n = 1'b1;
        exp_cnt = 16'd0;
        idle_cycles(1);
        good_packet("after_rst", 8'h10, 8'hA5);

        // Packet counter wrap, counter preloaded near the top
        force dut.Pkt_Cnt = 16'hFFFE;
        @(negedge Clk);
        release dut.Pkt_Cnt;
        exp_cnt = 16'hFFFE;
        good_packet("wrap_ffff", 8'h40, 8'h02);
        good_packet("wrap_0000", 8'h41, 8'h03);
        check("wrap_zero", 32'(Pkt_Cnt), 32'd0);

        idle_cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 500000, inter-byte timeout in Clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter HEADER, default 8'h55, packet start byte.
REQ-003 SHALL have port Clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Rx_Done  input  1  one-cycle strobe from the UART receiver: Data_Byte valid.
REQ-006 SHALL have port Data_Byte  input  8  received byte, sampled only when Rx_Done=1.
REQ-007 SHALL have port Baud_Set  output  3  baud selection driven to the UART receiver.
REQ-008 SHALL have port Wr_En  output  1  one-cycle register-write strobe.
REQ-009 SHALL have port Wr_Addr  output  8  write address, valid while Wr_En=1.
REQ-010 SHALL have port Wr_Data  output  8  write data, valid while Wr_En=1.
REQ-011 SHALL have port Err_Csum  output  1  one-cycle pulse on checksum mismatch.
REQ-012 SHALL have port Err_Timeout  output  1  one-cycle pulse on inter-byte timeout.
REQ-013 SHALL have port Pkt_Cnt  output  16  count of good packets.
REQ-014 SHALL have port Busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL define the packet as four bytes: HEADER, ADDR, DATA, CSUM, where CSUM = (ADDR+DATA) mod 256.
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA and CSUM; the state advances only on Rx_Done.
REQ-017 SHALL make the following transitions: IDLE->ADDR on Rx_Done with Data_Byte==HEADER; other bytes in IDLE are ignored with no error.
REQ-018 SHALL make the following transitions: ADDR->DATA latches ADDR; DATA->CSUM latches DATA; CSUM->IDLE always.
REQ-019 SHALL, on the CSUM byte, compare with the 8-bit sum; on a match, assert Wr_En with the latched Wr_Addr/Wr_Data in the cycle after Rx_Done, for one cycle.
REQ-020 SHALL, on a CSUM mismatch, pulse Err_Csum for one cycle in the cycle after Rx_Done, with no Wr_En and no Pkt_Cnt change.
REQ-021 SHALL treat a HEADER value received in ADDR/DATA/CSUM as payload; there is no resynchronisation.
REQ-022 SHALL, on a good packet with ADDR==8'h00, update Baud_Set to DATA[2:0] in the same cycle as Wr_En; DATA[7:3] are ignored and Wr_En is still issued.
REQ-023 SHALL increment Pkt_Cnt by 1 on each good packet, in the same cycle as Wr_En, wrapping 16'hFFFF->16'h0000.
REQ-024 SHALL run the timeout counter only in non-IDLE states, clearing it on entry to ADDR and on every Rx_Done.
REQ-025 SHALL, when the timeout counter reaches TIMEOUT_CYC-1 without Rx_Done, return the FSM to IDLE, pulse Err_Timeout for one cycle, and discard the partial packet.
REQ-026 SHALL let Rx_Done win over timeout expiry when both occur in the same cycle: the byte is processed and no Err_Timeout is raised.
REQ-027 SHALL drive Busy combinationally from state: Busy=1 in ADDR, DATA and CSUM.
REQ-028 SHALL accept back-to-back packets: a HEADER arriving on any Rx_Done after the CSUM byte starts a new packet with no dead cycle.

Reset
REQ-029 SHALL, on Rst_n=0, asynchronously force state IDLE, Baud_Set=3'd0, Wr_En=0, Wr_Addr=0, Wr_Data=0, Err_Csum=0, Err_Timeout=0, Pkt_Cnt=0 and timeout counter=0.
REQ-030 SHALL, on reset mid-packet, discard the packet and raise no error pulse; behaviour after release is identical to power-up.

Structure
REQ-031 SHALL place the FSM state enum, the HEADER default and the BAUD_ADDR constant (8'h00) in shared package uart_pkg.
REQ-032 SHALL implement the timeout counter as sub-module uart_timeout_cnt (inputs clear and enable, output expire pulse), parameterised by TIMEOUT_CYC.

Verification
REQ-033 SHALL cover: bytes 55,10,A5,B5 -> Wr_En one cycle after the 4th Rx_Done, Wr_Addr=10, Wr_Data=A5, Pkt_Cnt=1.
REQ-034 SHALL cover: bytes 55,00,03,03 -> Baud_Set=3 and Wr_En in the same cycle; then bytes 55,00,FC,FC -> Baud_Set=4.
REQ-035 SHALL cover: bytes 55,10,A5,00 -> Err_Csum one-cycle pulse, no Wr_En, Pkt_Cnt unchanged, Busy=0 afterwards.
REQ-036 SHALL cover: bytes 55,10 followed by silence (TIMEOUT_CYC=100) -> Err_Timeout pulse after 100 cycles, state IDLE; a following good packet is accepted.
REQ-037 SHALL cover: Rx_Done coincident with the expiry cycle -> no Err_Timeout, byte accepted; Rst_n low after 55,10 -> Busy=0, all outputs at reset values, no error pulse.
REQ-038 SHALL cover: Pkt_Cnt preloaded to 16'hFFFF by 65535 good packets, then one more good packet -> Pkt_Cnt=0; leading bytes 00,AA before 55 are ignored.
